apb_ram_be: RTL

Parametrised APB slave RAM, successor to the fixed 32-bit/1K-word APB RAM peripheral. Adds configurable data width, depth and wait states, APB4 byte strobes (PSTRB), and PSLVERR for out-of-range word addresses. Sits on the APB bus behind the bus master/decoder as a memory-mapped scratch/data store.

---
 rtl/apb_ram_be_pkg.sv | 25 ++
 rtl/apb_ram_be_ram.sv | 39 +++
 rtl/apb_ram_be.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/apb_ram_be_pkg.sv
// Shared types and width helpers for the byte-strobed APB scratch RAM.
package apb_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Wait-state counter width covers WAIT_CYC up to 15.
    localparam int CNT_W = 4;

    function automatic int ofs_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int idx_w(input int addr_w, input int data_w);
        return addr_w - ofs_w(data_w);
    endfunction

    function automatic int ram_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb_ram_be_ram.sv
// Single-port synchronous RAM with per-byte write enables and registered read.
// Each byte lane is its own array so the lanes map onto byte-wide block RAM.
module ram_be_sp
    import apb_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int BYTES = DATA_W / 8;

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] mem_q [DEPTH];
            logic [7:0] rdata_q;

            always_ff @(posedge clk_i) begin
                if (we_i && be_i[gi]) begin
                    mem_q[addr_i] <= wdata_i[gi*8 +: 8];
                end
                if (re_i) begin
                    rdata_q <= mem_q[addr_i];
                end
            end

            assign rdata_o[gi*8 +: 8] = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/apb_ram_be.sv
// APB4 slave RAM: configurable width/depth/wait states, PSTRB byte writes and
// PSLVERR on word indices beyond DEPTH.
module apb_ram_be
    import apb_ram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12,
    parameter int DEPTH    = 1024,
    parameter int WAIT_CYC = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_W-1:0]     PADDR,
    input  logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W/8-1:0]   PSTRB,
    output logic [DATA_W-1:0]     PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFS   = ofs_w(DATA_W);
    localparam int IDX_W = idx_w(ADDR_W, DATA_W);
    localparam int AW    = ram_aw(DEPTH);

    localparam logic [IDX_W:0]   DEPTH_L  = (IDX_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYC > 0) ? CNT_W'(WAIT_CYC - 1) : '0;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               write_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [BYTES-1:0]   strb_q;
    logic               pready_q;
    logic               pslverr_q;
    logic               rd_zero_q;

    logic               access;
    logic               in_idle;
    logic               commit;
    logic               c_write;
    logic               c_ok;
    logic [IDX_W-1:0]   c_idx;
    logic [DATA_W-1:0]  c_wdata;
    logic [BYTES-1:0]   c_strb;
    logic [IDX_W-1:0]   paddr_idx;
    logic               ram_we;
    logic               ram_re;
    logic [AW-1:0]      ram_addr;
    logic [DATA_W-1:0]  ram_rdata;
    logic               unused_paddr;

    // Sub-word address bits select nothing; they are deliberately dropped.
    assign paddr_idx    = PADDR[ADDR_W-1:OFS];
    assign unused_paddr = ^PADDR;

    // With no wait states the commit happens straight out of IDLE, so the
    // live bus fields are used; otherwise the copies latched in IDLE are used.
    always_comb begin
        access  = PSEL && PENABLE;
        in_idle = (state_q == IDLE);
        c_write = in_idle ? PWRITE    : write_q;
        c_idx   = in_idle ? paddr_idx : idx_q;
        c_wdata = in_idle ? PWDATA    : wdata_q;
        c_strb  = in_idle ? PSTRB     : strb_q;
        commit  = access && ((in_idle && (WAIT_CYC == 0)) ||
                             ((state_q == WAIT) && (cnt_q == '0)));
        c_ok    = ({1'b0, c_idx} < DEPTH_L);
    end

    assign ram_we   = commit && c_write && c_ok;
    assign ram_re   = commit && !c_write && c_ok;
    assign ram_addr = c_idx[AW-1:0];

    ram_be_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk_i   (PCLK),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .be_i    (c_strb),
        .addr_i  (ram_addr),
        .wdata_i (c_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            rd_zero_q <= 1'b1;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            if (commit) begin
                pready_q  <= 1'b1;
                pslverr_q <= !c_ok;
                // Only reads touch PRDATA: valid reads expose the RAM word,
                // out-of-range reads force zero.
                if (!c_write) begin
                    rd_zero_q <= !c_ok;
                end
            end

            case (state_q)
                IDLE: begin
                    if (access) begin
                        write_q <= PWRITE;
                        idx_q   <= paddr_idx;
                        wdata_q <= PWDATA;
                        strb_q  <= PSTRB;
                        if (WAIT_CYC == 0) begin
                            state_q <= RESP;
                        end else begin
                            cnt_q   <= CNT_INIT;
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!access) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // PRDATA is a mux of registers only, so it stays a registered output.
    assign PRDATA  = rd_zero_q ? '0 : ram_rdata;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule
